// File: rtl/otp_ctrl_part_buf_loader_pkg.sv
// Shared types and constants for the OTP partition buffer loader.
package otp_ctrl_part_buf_loader_pkg;

    // Sparse state codes: every pair of codes differs in at least three bits,
    // so a single or double upset never lands on another legal state.
    // Six bits are the fewest that hold five codes at that distance.
    typedef enum logic [5:0] {
        StIdle  = 6'b000000,
        StReq   = 6'b111000,
        StWait  = 6'b100110,
        StDone  = 6'b010101,
        StError = 6'b001111
    } state_e;

    // Bytes per partition word in the OTP byte address space.
    localparam int unsigned WordBytes = 8;

    // Bits needed to index n entries (at least one bit).
    function automatic int vbits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/otp_ctrl_part_buf_loader.sv
// Loads a buffered OTP partition word by word into the ECC register file,
// then watches the register file for ECC errors and latches a terminal error.
module otp_ctrl_part_buf_loader
    import otp_ctrl_part_buf_loader_pkg::*;
#(
    parameter int          NumWords = 16,
    parameter int          OtpAw    = 11,
    parameter int unsigned BaseAddr = 0,
    parameter int          Aw       = vbits(NumWords)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             init_req_i,
    output logic             init_done_o,
    output logic             error_o,
    output logic             otp_req_o,
    output logic [OtpAw-1:0] otp_addr_o,
    input  logic             otp_gnt_i,
    input  logic             otp_rvalid_i,
    input  logic [63:0]      otp_rdata_i,
    input  logic             otp_err_i,
    output logic             buf_wren_o,
    output logic [Aw-1:0]    buf_addr_o,
    output logic [63:0]      buf_wdata_o,
    input  logic             buf_ecc_err_i
);

    // One spare counter bit so an out-of-range index is representable and detectable.
    localparam int            CntW    = Aw + 1;
    localparam logic [CntW-1:0] LastIdx = CntW'(NumWords - 1);

    state_e             r_state;
    logic [CntW-1:0]    r_cnt;
    logic               r_otp_req;
    logic [OtpAw-1:0]   r_otp_addr;
    logic               r_init_done;
    logic               r_error;

    logic               w_cnt_bad;
    logic               w_write;
    logic               w_fault;

    // OTP byte address of word idx, truncated to the macro address width.
    function automatic logic [OtpAw-1:0] word_addr(input logic [CntW-1:0] idx);
        logic [31:0] full;
        full = 32'(BaseAddr) + 32'(idx) * 32'(WordBytes);
        return full[OtpAw-1:0];
    endfunction

    assign w_cnt_bad = (r_cnt > LastIdx);

    // A clean read response in Wait is written straight through to the buffer.
    assign w_write = (r_state == StWait) && otp_rvalid_i && !otp_err_i && !w_cnt_bad;

    // Collect every condition that sends the loader to its terminal error state.
    always_comb begin
        w_fault = w_cnt_bad;
        case (r_state)
            StIdle:  w_fault = w_fault || otp_rvalid_i;
            StReq:   w_fault = w_fault || otp_rvalid_i;
            StWait:  w_fault = w_fault || (otp_rvalid_i && otp_err_i);
            StDone:  w_fault = w_fault || otp_rvalid_i || buf_ecc_err_i;
            StError: w_fault = 1'b1;
            default: w_fault = 1'b1;
        endcase
    end

    // Main FSM with word counter and registered handshake/status outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_otp_req   <= 1'b0;
            r_otp_addr  <= '0;
            r_init_done <= 1'b0;
            r_error     <= 1'b0;
        end else if (w_fault) begin
            r_state     <= StError;
            r_otp_req   <= 1'b0;
            r_otp_addr  <= '0;
            r_init_done <= 1'b0;
            r_error     <= 1'b1;
        end else begin
            case (r_state)
                StIdle: begin
                    if (init_req_i) begin
                        r_state    <= StReq;
                        r_cnt      <= '0;
                        r_otp_req  <= 1'b1;
                        r_otp_addr <= word_addr('0);
                    end
                end
                StReq: begin
                    if (otp_gnt_i) begin
                        r_state   <= StWait;
                        r_otp_req <= 1'b0;
                    end
                end
                StWait: begin
                    if (otp_rvalid_i) begin
                        if (r_cnt == LastIdx) begin
                            r_state     <= StDone;
                            r_init_done <= 1'b1;
                        end else begin
                            r_state    <= StReq;
                            r_cnt      <= r_cnt + CntW'(1);
                            r_otp_req  <= 1'b1;
                            r_otp_addr <= word_addr(r_cnt + CntW'(1));
                        end
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    assign init_done_o = r_init_done;
    assign error_o     = r_error;
    assign otp_req_o   = r_otp_req;
    assign otp_addr_o  = r_otp_addr;
    assign buf_wren_o  = w_write;
    assign buf_addr_o  = r_cnt[Aw-1:0];
    assign buf_wdata_o = w_write ? otp_rdata_i : 64'd0;

`ifndef SYNTHESIS
    a_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !$isunknown({init_done_o, error_o, otp_req_o, otp_addr_o, buf_wren_o, buf_addr_o, buf_wdata_o}));
    a_addr_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (otp_req_o && !otp_gnt_i) |=> ($stable(otp_addr_o) || error_o));
    a_wren_single: assert property (@(posedge clk_i) disable iff (!rst_ni)
        buf_wren_o |=> !buf_wren_o);
`endif

endmodule
